// File: rtl/match_controller.sv
// Round/match sequencer: engine reset, pre-round countdown, play, hit scoring and match winner.
// Optional round time limit is compiled in with MATCH_TIMEOUT_EN (ends an unhit round as a draw).
module match_controller #(
  parameter int WIN_ROUNDS       = 3,
  parameter int SCORE_W          = 4,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int HOLD_FRAMES      = 120,
  parameter int ENG_RST_CYCLES   = 4,
  parameter int ROUND_FRAMES     = 3600,
  parameter int CW               = $clog2(COUNTDOWN_FRAMES + 1)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_frame_tick,
  input  logic               i_hit_player,
  input  logic               i_hit_opponent,
  output logic               o_engine_reset,
  output logic               o_game_on,
  output logic [2:0]         o_state,
  output logic [CW-1:0]      o_countdown,
  output logic [SCORE_W-1:0] o_score1,
  output logic [SCORE_W-1:0] o_score2,
  output logic [1:0]         o_round_result,
  output logic [1:0]         o_winner
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ENG_RST    = 3'd1,
    S_COUNTDOWN  = 3'd2,
    S_PLAY       = 3'd3,
    S_ROUND_END  = 3'd4,
    S_MATCH_OVER = 3'd5
  } state_t;

  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam int RW = $clog2(ENG_RST_CYCLES + 1);
  localparam logic [CW-1:0]      CD_LOAD   = CW'(COUNTDOWN_FRAMES);
  localparam logic [CW-1:0]      CD_ONE    = CW'(1);
  localparam logic [HW-1:0]      HOLD_LOAD = HW'(HOLD_FRAMES);
  localparam logic [HW-1:0]      HOLD_ONE  = HW'(1);
  localparam logic [RW-1:0]      RST_LAST  = RW'(ENG_RST_CYCLES - 1);
  localparam logic [RW-1:0]      RST_ONE   = RW'(1);
  localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_ROUNDS);
  localparam logic [SCORE_W-1:0] SC_ONE    = SCORE_W'(1);

  if (WIN_ROUNDS < 1 || WIN_ROUNDS >= (2 ** SCORE_W) || COUNTDOWN_FRAMES < 1 ||
      HOLD_FRAMES < 1 || ENG_RST_CYCLES < 1 || ROUND_FRAMES < 1) begin : g_bad_params
    $error("match_controller: parameter out of range");
  end

  state_t             r_state;
  logic               r_engine_reset;
  logic               r_game_on;
  logic [CW-1:0]      r_countdown;
  logic [SCORE_W-1:0] r_score1;
  logic [SCORE_W-1:0] r_score2;
  logic [1:0]         r_round_result;
  logic [1:0]         r_winner;
  logic [HW-1:0]      r_hold_cnt;
  logic [RW-1:0]      r_rst_cnt;
  logic               w_hit_any;
  logic               w_timeout;

  assign w_hit_any = i_hit_player | i_hit_opponent;

`ifdef MATCH_TIMEOUT_EN
  localparam int FW = $clog2(ROUND_FRAMES + 1);
  localparam logic [FW-1:0] FR_LOAD = FW'(ROUND_FRAMES);
  localparam logic [FW-1:0] FR_ONE  = FW'(1);
  logic [FW-1:0] r_frame_cnt;

  assign w_timeout = i_frame_tick && (r_frame_cnt == FR_ONE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_frame_cnt <= '0;
    end else if (r_state == S_COUNTDOWN && i_frame_tick && r_countdown == CD_ONE) begin
      r_frame_cnt <= FR_LOAD;
    end else if (r_state == S_PLAY && i_frame_tick && r_frame_cnt != '0) begin
      r_frame_cnt <= r_frame_cnt - FR_ONE;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_engine_reset <= 1'b1;
      r_game_on      <= 1'b0;
      r_countdown    <= '0;
      r_score1       <= '0;
      r_score2       <= '0;
      r_round_result <= 2'd0;
      r_winner       <= 2'd0;
      r_hold_cnt     <= '0;
      r_rst_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_score1  <= '0;
            r_score2  <= '0;
            r_rst_cnt <= RST_LAST;
            r_state   <= S_ENG_RST;
          end
        end
        S_ENG_RST: begin
          if (r_rst_cnt == '0) begin
            r_engine_reset <= 1'b0;
            r_countdown    <= CD_LOAD;
            r_state        <= S_COUNTDOWN;
          end else begin
            r_rst_cnt <= r_rst_cnt - RST_ONE;
          end
        end
        S_COUNTDOWN: begin
          if (i_frame_tick) begin
            r_countdown <= r_countdown - CD_ONE;
            if (r_countdown == CD_ONE) begin
              r_game_on <= 1'b1;
              r_state   <= S_PLAY;
            end
          end
        end
        S_PLAY: begin
          // A hit outranks a timeout landing on the same cycle.
          if (w_hit_any || w_timeout) begin
            r_game_on  <= 1'b0;
            r_hold_cnt <= HOLD_LOAD;
            r_state    <= S_ROUND_END;
            if (i_hit_player && i_hit_opponent) begin
              r_round_result <= 2'd3;
            end else if (i_hit_opponent) begin
              r_score1       <= r_score1 + SC_ONE;
              r_round_result <= 2'd1;
            end else if (i_hit_player) begin
              r_score2       <= r_score2 + SC_ONE;
              r_round_result <= 2'd2;
            end else begin
              r_round_result <= 2'd3;
            end
          end
        end
        S_ROUND_END: begin
          if (i_frame_tick) begin
            if (r_hold_cnt == HOLD_ONE) begin
              if (r_score1 == WIN || r_score2 == WIN) begin
                r_winner <= (r_score1 == WIN) ? 2'd1 : 2'd2;
                r_state  <= S_MATCH_OVER;
              end else begin
                r_engine_reset <= 1'b1;
                r_rst_cnt      <= RST_LAST;
                r_state        <= S_ENG_RST;
              end
            end else begin
              r_hold_cnt <= r_hold_cnt - HOLD_ONE;
            end
          end
        end
        S_MATCH_OVER: begin
          if (i_start) begin
            r_score1       <= '0;
            r_score2       <= '0;
            r_winner       <= 2'd0;
            r_round_result <= 2'd0;
            r_engine_reset <= 1'b1;
            r_rst_cnt      <= RST_LAST;
            r_state        <= S_ENG_RST;
          end
        end
        default: begin
          r_engine_reset <= 1'b1;
          r_game_on      <= 1'b0;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

  assign o_state        = r_state;
  assign o_engine_reset = r_engine_reset;
  assign o_game_on      = r_game_on;
  assign o_countdown    = r_countdown;
  assign o_score1       = r_score1;
  assign o_score2       = r_score2;
  assign o_round_result = r_round_result;
  assign o_winner       = r_winner;

endmodule
